// File: rtl/sm_sum_fifo_if.sv
// rtl/sm_sum_fifo_if.sv - bus bundle between the sum stage, sm_sum_fifo and its consumer
//
// Purpose: groups the producer pulse, consumer handshake and status signals
// of sm_sum_fifo so they travel as one port.
//
// Signals:
//   i_dval   sum valid pulse from the sum stage (no backpressure)
//   i        sum value, sampled when i_dval=1
//   o_valid  head entry valid
//   o_ready  consumer accepts head this cycle
//   o        head entry value (0 when empty)
//   level    current occupancy, 0..DEPTH
//   full     level == DEPTH
//   ovf_cnt  saturating count of dropped sums
//
// Modports:
//   master   producer/consumer side (drives i_dval, i, o_ready)
//   slave    FIFO side (drives o_valid, o, level, full, ovf_cnt)

interface sm_sum_fifo_if #(
   parameter int IW    = 10,
   parameter int SW    = IW + 2,
   parameter int DEPTH = 4,
   parameter int CW    = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          i_dval;
   logic [SW-1:0] i;
   logic          o_valid;
   logic          o_ready;
   logic [SW-1:0] o;
   logic [LW-1:0] level;
   logic          full;
   logic [CW-1:0] ovf_cnt;

   modport master (
      output i_dval,
      output i,
      output o_ready,
      input  o_valid,
      input  o,
      input  level,
      input  full,
      input  ovf_cnt
   );

   modport slave (
      input  i_dval,
      input  i,
      input  o_ready,
      output o_valid,
      output o,
      output level,
      output full,
      output ovf_cnt
   );
endinterface

// File: rtl/sm_sum_fifo.sv
// rtl/sm_sum_fifo.sv - FWFT buffer capturing sum pulses with overflow counting
//
// Purpose: captures each i_dval/i sum pulse from the sum-every-3 stage into a
// small first-word-fall-through FIFO, presents the head on a valid/ready
// handshake and counts sums dropped on overflow (saturating).
//
// Ports:
//   clk   clock; all state updates on posedge
//   rst   asynchronous active-high reset; clears pointers, level, ovf_cnt
//   bus   sm_sum_fifo_if.slave: i_dval, i, o_ready in;
//         o_valid, o, level, full, ovf_cnt out

module sm_sum_fifo #(
   parameter int IW    = 10,
   parameter int SW    = IW + 2,
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic            clk,
   input  logic            rst,
   sm_sum_fifo_if.slave    bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   // Storage has no reset: contents are only ever observed through level.
   logic [SW-1:0] mem_q [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CW-1:0] ovf_q, ovf_d;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;

   always_comb begin
      empty = (level_q == '0);
      full  = (level_q == LW'(DEPTH));
      pop   = ~empty & bus.o_ready;
      // A full FIFO still accepts a sum when the head leaves in the same cycle.
      push  = bus.i_dval & (~full | pop);
      drop  = bus.i_dval & full & ~pop;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      level_d = level_q;
      ovf_d   = ovf_q;

      // Pointers wrap naturally; full vs empty is told apart by level.
      if (push) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end

      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end

      if (drop && (ovf_q != {CW{1'b1}})) begin
         ovf_d = ovf_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wptr_q] <= bus.i;
      end
   end

   // Head is forced to 0 when empty so stale storage never reaches the consumer.
   assign bus.o_valid = ~empty;
   assign bus.o       = empty ? '0 : mem_q[rptr_q];
   assign bus.level   = level_q;
   assign bus.full    = full;
   assign bus.ovf_cnt = ovf_q;

endmodule

// File: tb/tb_sm_sum_fifo.sv
// tb/tb_sm_sum_fifo.sv - self-checking bench for sm_sum_fifo
//
// Purpose: drives directed vectors, multi-cycle corner sequences and a
// randomized scoreboard run against sm_sum_fifo.
//
// Ports: none (top-level bench).

module tb_sm_sum_fifo;

   logic clk;
   logic rst;

   int n_tests;
   int n_fail;

   sm_sum_fifo_if #(.IW(10), .SW(12), .DEPTH(4), .CW(8)) bus ();

   sm_sum_fifo #(.IW(10), .SW(12), .DEPTH(4), .CW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dval;
      logic [11:0] din;
      logic        rdy;
      logic        exp_valid;
      logic [11:0] exp_o;
      logic [2:0]  exp_lvl;
      logic        exp_full;
      logic [7:0]  exp_ovf;
   } vec_t;

   vec_t vecs[15];

   logic [11:0] q[$];
   logic [7:0]  m_ovf;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic v, input logic [11:0] o,
                          input logic [2:0] l, input logic f, input logic [7:0] ov);
      chk({nm, ".o_valid"}, 32'(bus.o_valid), 32'(v));
      chk({nm, ".o"},       32'(bus.o),       32'(o));
      chk({nm, ".level"},   32'(bus.level),   32'(l));
      chk({nm, ".full"},    32'(bus.full),    32'(f));
      chk({nm, ".ovf_cnt"}, 32'(bus.ovf_cnt), 32'(ov));
   endtask

   task automatic drive(input logic d, input logic [11:0] v, input logic r);
      bus.i_dval  = d;
      bus.i       = v;
      bus.o_ready = r;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // latency, hold, pop, ready-while-empty, fill, overflow, simultaneous, drain
      vecs[0]  = '{1'b1, 12'h0A5, 1'b0, 1'b1, 12'h0A5, 3'd1, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 12'h000, 1'b0, 1'b1, 12'h0A5, 3'd1, 1'b0, 8'd0};
      vecs[2]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0, 8'd0};
      vecs[4]  = '{1'b1, 12'h001, 1'b0, 1'b1, 12'h001, 3'd1, 1'b0, 8'd0};
      vecs[5]  = '{1'b1, 12'h002, 1'b0, 1'b1, 12'h001, 3'd2, 1'b0, 8'd0};
      vecs[6]  = '{1'b1, 12'h003, 1'b0, 1'b1, 12'h001, 3'd3, 1'b0, 8'd0};
      vecs[7]  = '{1'b1, 12'h004, 1'b0, 1'b1, 12'h001, 3'd4, 1'b1, 8'd0};
      vecs[8]  = '{1'b1, 12'h005, 1'b0, 1'b1, 12'h001, 3'd4, 1'b1, 8'd1};
      vecs[9]  = '{1'b1, 12'h006, 1'b0, 1'b1, 12'h001, 3'd4, 1'b1, 8'd2};
      vecs[10] = '{1'b1, 12'h007, 1'b1, 1'b1, 12'h002, 3'd4, 1'b1, 8'd2};
      vecs[11] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h003, 3'd3, 1'b0, 8'd2};
      vecs[12] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h004, 3'd2, 1'b0, 8'd2};
      vecs[13] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h007, 3'd1, 1'b0, 8'd2};
      vecs[14] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0, 8'd2};

      // Power-on reset
      rst = 1'b1;
      drive(1'b0, 12'h000, 1'b0);
      cyc();
      cyc();
      chk_all("reset", 1'b0, 12'h000, 3'd0, 1'b0, 8'd0);
      rst = 1'b0;

      // Directed table
      for (int k = 0; k < 15; k++) begin
         drive(vecs[k].dval, vecs[k].din, vecs[k].rdy);
         cyc();
         chk_all($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_o,
                 vecs[k].exp_lvl, vecs[k].exp_full, vecs[k].exp_ovf);
      end

      // Saturation: fill 1..4, then 300 drops; contents must be untouched
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, 12'(k), 1'b0);
         cyc();
      end
      for (int k = 0; k < 300; k++) begin
         drive(1'b1, 12'(500 + k), 1'b0);
         cyc();
      end
      chk_all("sat", 1'b1, 12'h001, 3'd4, 1'b1, 8'd255);
      for (int k = 1; k <= 4; k++) begin
         drive(1'b0, 12'h000, 1'b1);
         chk($sformatf("sat_drain%0d", k), 32'(bus.o), 32'(k));
         cyc();
      end
      chk_all("sat_empty", 1'b0, 12'h000, 3'd0, 1'b0, 8'd255);

      // Asynchronous reset mid-stream at level 3
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 12'(20 + k), 1'b0);
         cyc();
      end
      drive(1'b0, 12'h000, 1'b0);
      chk("pre_rst.level", 32'(bus.level), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 12'h000, 3'd0, 1'b0, 8'd0);
      cyc();
      rst = 1'b0;
      cyc();
      chk_all("post_rst", 1'b0, 12'h000, 3'd0, 1'b0, 8'd0);

      // Wrap-around: level held at 1 while 100..109 stream through
      drive(1'b1, 12'd100, 1'b0);
      cyc();
      for (int k = 1; k <= 9; k++) begin
         drive(1'b1, 12'(100 + k), 1'b1);
         chk($sformatf("wrap%0d.o", k - 1), 32'(bus.o), 32'(100 + k - 1));
         chk($sformatf("wrap%0d.level", k - 1), 32'(bus.level), 32'd1);
         cyc();
      end
      drive(1'b0, 12'h000, 1'b1);
      chk("wrap9.o", 32'(bus.o), 32'd109);
      cyc();
      chk_all("wrap_end", 1'b0, 12'h000, 3'd0, 1'b0, 8'd0);

      // Random scoreboard
      q.delete();
      m_ovf = 8'd0;
      for (int c = 0; c < 5000; c++) begin
         logic        d;
         logic        r;
         logic [11:0] v;
         logic        m_pop;
         logic        m_push;
         logic        m_drop;
         logic        ok;
         d = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 99) < ((c < 2500) ? 30 : 70));
         v = 12'($urandom);
         drive(d, v, r);
         m_pop  = (q.size() != 0) && r;
         m_push = d && ((q.size() < 4) || m_pop);
         m_drop = d && (q.size() == 4) && !m_pop;
         cyc();
         if (m_pop)  void'(q.pop_front());
         if (m_push) q.push_back(v);
         if (m_drop && (m_ovf != 8'd255)) m_ovf = m_ovf + 8'd1;
         ok = (bus.o_valid === (q.size() != 0)) &&
              (32'(bus.level) === q.size()) &&
              (bus.full === (q.size() == 4)) &&
              (bus.ovf_cnt === m_ovf) &&
              (bus.o === ((q.size() == 0) ? 12'h000 : q[0]));
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL rand%0d: got valid=%0b o=%0h level=%0d full=%0b ovf=%0d expected level=%0d o=%0h ovf=%0d",
                     c, bus.o_valid, bus.o, bus.level, bus.full, bus.ovf_cnt,
                     q.size(), (q.size() == 0) ? 12'h000 : q[0], m_ovf);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
